// File: rtl/uart_adder_ctrl.sv
// UART-framed adder controller: gathers two operands from RX bytes, picks one of
// NMODES external adder sums after LAT cycles, and replies with header + sum on TX.
module uart_adder_ctrl #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned NMODES  = 4,
  parameter int unsigned LAT     = 1,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NMODES-1:0]       mode_btn_i,
  input  logic                    rx_dv_i,
  input  logic [7:0]              rx_byte_i,
  output logic                    tx_start_o,
  output logic [7:0]              tx_byte_o,
  input  logic                    tx_active_i,
  input  logic                    tx_done_i,
  output logic [WIDTH-1:0]        num1_o,
  output logic [WIDTH-1:0]        num2_o,
  input  logic [NMODES*WIDTH-1:0] sum_i,
  output logic [2:0]              mode_o,
  output logic                    busy_o,
  output logic                    err_o
);
  localparam int unsigned NBYTES      = WIDTH / 8;
  localparam int unsigned FRAME_BYTES = 2 * NBYTES;
  localparam int unsigned RESP_BYTES  = NBYTES + 1;
  localparam int unsigned RESP_W      = 8 * RESP_BYTES;
  localparam int unsigned CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam int unsigned TX_W        = $clog2(RESP_BYTES + 1);
  localparam int unsigned TMO_W       = $clog2(TIMEOUT + 1);
  localparam int unsigned LAT_W       = 4;

  typedef enum logic [2:0] {IDLE, RX, COMPUTE, SEND, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [NMODES-1:0]  btn_q;
  logic [NMODES-1:0]  btn_rise;
  logic [2:0]         mode_d;
  logic [2*WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [2:0]         mode_lat_q, mode_lat_d;
  logic [RESP_W-1:0]  resp_q, resp_d;
  logic [TX_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [WIDTH-1:0]   num1_d, num2_d, sum_sel;
  logic               tx_start_d, busy_d, err_d;
  logic [7:0]         tx_byte_d;

  // Mode select: rising button edge, lowest index wins
  always_comb begin
    btn_rise = mode_btn_i & ~btn_q;
    mode_d   = mode_o;
    for (int k = int'(NMODES) - 1; k >= 0; k--) begin
      if (btn_rise[k]) mode_d = 3'(k);
    end
  end

  // Sum slice of the mode latched at compute start
  always_comb begin
    sum_sel = '0;
    for (int unsigned k = 0; k < NMODES; k++) begin
      if (mode_lat_q == 3'(k)) sum_sel = sum_i[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    lat_d      = lat_q;
    mode_lat_d = mode_lat_q;
    resp_d     = resp_q;
    tx_cnt_d   = tx_cnt_q;
    num1_d     = num1_o;
    num2_d     = num2_o;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_o;
    busy_d     = busy_o;
    err_d      = err_o;
    shift_in   = {shift_q[2*WIDTH-9:0], rx_byte_i};

    unique case (state_q)
      IDLE: begin
        if (rx_dv_i) begin
          shift_d    = shift_in;
          byte_cnt_d = CNT_W'(1);
          tmo_d      = '0;
          busy_d     = 1'b1;
          state_d    = RX;
        end
      end
      RX: begin
        // A byte on the timeout cycle wins over the timeout
        if (rx_dv_i) begin
          shift_d = shift_in;
          tmo_d   = '0;
          if (byte_cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
            num1_d     = shift_in[2*WIDTH-1 -: WIDTH];
            num2_d     = shift_in[WIDTH-1:0];
            mode_lat_d = mode_o;
            lat_d      = '0;
            byte_cnt_d = '0;
            state_d    = COMPUTE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          byte_cnt_d = '0;
          tmo_d      = '0;
          busy_d     = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COMPUTE: begin
        if (lat_q == LAT_W'(LAT - 1)) begin
          resp_d   = {8'hA0 | {5'b0, mode_lat_q}, sum_sel};
          tx_cnt_d = '0;
          state_d  = SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      SEND: begin
        if (!tx_active_i) begin
          tx_start_d = 1'b1;
          tx_byte_d  = resp_q[RESP_W-1 -: 8];
          resp_d     = resp_q << 8;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done_i) begin
          if (tx_cnt_q == TX_W'(RESP_BYTES - 1)) begin
            tx_cnt_d = '0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            state_d  = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bytes arriving while a result is in flight are dropped and flagged
    if (rx_dv_i && (state_q inside {COMPUTE, SEND, WAIT_DONE})) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q      <= '0;
      mode_o     <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      lat_q      <= '0;
      mode_lat_q <= '0;
      resp_q     <= '0;
      tx_cnt_q   <= '0;
      num1_o     <= '0;
      num2_o     <= '0;
      tx_start_o <= 1'b0;
      tx_byte_o  <= '0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      btn_q      <= mode_btn_i;
      mode_o     <= mode_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      lat_q      <= lat_d;
      mode_lat_q <= mode_lat_d;
      resp_q     <= resp_d;
      tx_cnt_q   <= tx_cnt_d;
      num1_o     <= num1_d;
      num2_o     <= num2_d;
      tx_start_o <= tx_start_d;
      tx_byte_o  <= tx_byte_d;
      busy_o     <= busy_d;
      err_o      <= err_d;
    end
  end

endmodule
